// File: rtl/plic_gateway.sv
// plic_gateway: per-source synchroniser and level/edge gating in front of the PLIC, one request outstanding per source.
// Level requests issue SYNC_STAGES cycles after the raw line rises, edge requests one cycle later; each source waits for its completion.
module plic_gateway #(
  parameter int SOURCES     = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_CNT_W  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [SOURCES-1:0]         irq_raw_i,
  input  logic [SOURCES-1:0]         edge_mode_i,
  input  logic                       complete_valid_i,
  input  logic [$clog2(SOURCES)-1:0] complete_id_i,
  output logic [SOURCES-1:0]         irq_req_o,
  output logic [SOURCES-1:0]         inflight_o,
  output logic [SOURCES-1:0]         edge_ovf_o,
  input  logic [SOURCES-1:0]         ovf_clr_i
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [EDGE_CNT_W-1:0] CNT_MAX = '1;

  // Source 0 is reserved: its inputs are intentionally dropped.
  logic unused_src0;
  assign unused_src0   = irq_raw_i[0] ^ edge_mode_i[0] ^ ovf_clr_i[0];
  assign irq_req_o[0]  = 1'b0;
  assign inflight_o[0] = 1'b0;
  assign edge_ovf_o[0] = 1'b0;

  for (genvar i = 1; i < SOURCES; i++) begin : g_src
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic                   s_d;
    logic                   rise;
    logic                   req_cond;
    logic                   issue;
    logic                   done;
    logic                   ovf_set;
    logic [EDGE_CNT_W-1:0]  cnt;
    logic                   req_q;
    logic                   ovf_q;
    state_t                 state;

    assign s        = sync_q[SYNC_STAGES-1];
    assign rise     = s & ~s_d;
    assign req_cond = edge_mode_i[i] ? (cnt != '0) : s;
    assign issue    = (state == IDLE) && req_cond;
    assign done     = complete_valid_i && (int'(complete_id_i) == i);
    // A rise that meets a same-cycle issue nets to zero, so it never overflows.
    assign ovf_set  = edge_mode_i[i] && rise && !issue && (cnt == CNT_MAX);

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
        s_d    <= 1'b0;
        state  <= IDLE;
        req_q  <= 1'b0;
        cnt    <= '0;
        ovf_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw_i[i]};
        s_d    <= s;

        case (state)
          IDLE: begin
            req_q <= req_cond;
            if (req_cond) state <= BUSY;
          end
          BUSY: begin
            req_q <= 1'b0;
            if (done) state <= IDLE;
          end
        endcase

        if (!edge_mode_i[i]) begin
          cnt <= '0;
        end else if (rise && !issue && (cnt != CNT_MAX)) begin
          cnt <= cnt + 1'b1;
        end else if (issue && !rise) begin
          cnt <= cnt - 1'b1;
        end

        if (ovf_set) begin
          ovf_q <= 1'b1;
        end else if (ovf_clr_i[i]) begin
          ovf_q <= 1'b0;
        end
      end
    end

    assign irq_req_o[i]  = req_q;
    assign inflight_o[i] = (state == BUSY);
    assign edge_ovf_o[i] = ovf_q;
  end

endmodule

// File: tb/tb_plic_gateway.sv
// Bench for plic_gateway: per-cycle vector table with expected outputs queued at drive time and checked after the edge.
module tb_plic_gateway;
  localparam int N  = 12;
  localparam int SS = 2;
  localparam int CW = 2;
  localparam int IW = $clog2(N);

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [N-1:0]  irq_raw_i;
  logic [N-1:0]  edge_mode_i;
  logic          complete_valid_i;
  logic [IW-1:0] complete_id_i;
  logic [N-1:0]  irq_req_o;
  logic [N-1:0]  inflight_o;
  logic [N-1:0]  edge_ovf_o;
  logic [N-1:0]  ovf_clr_i;

  typedef struct {
    logic [N-1:0]  raw;
    logic [N-1:0]  mode;
    logic          cv;
    logic [IW-1:0] cid;
    logic [N-1:0]  clr;
    logic [N-1:0]  req;
    logic [N-1:0]  infl;
    logic [N-1:0]  ovf;
  } vec_t;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] infl;
    logic [N-1:0] ovf;
    int           tag;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  always #5 clk_i = ~clk_i;

  plic_gateway #(.SOURCES(N), .SYNC_STAGES(SS), .EDGE_CNT_W(CW)) dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
    .irq_raw_i        (irq_raw_i),
    .edge_mode_i      (edge_mode_i),
    .complete_valid_i (complete_valid_i),
    .complete_id_i    (complete_id_i),
    .irq_req_o        (irq_req_o),
    .inflight_o       (inflight_o),
    .edge_ovf_o       (edge_ovf_o),
    .ovf_clr_i        (ovf_clr_i)
  );

  function automatic vec_t mk(int raw, int mode, int cv, int cid, int clr, int req, int infl, int ovf);
    vec_t v;
    v.raw  = N'(raw);
    v.mode = N'(mode);
    v.cv   = (cv != 0);
    v.cid  = IW'(cid);
    v.clr  = N'(clr);
    v.req  = N'(req);
    v.infl = N'(infl);
    v.ovf  = N'(ovf);
    return v;
  endfunction

  task automatic check(input string nm, input int tag, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s step %0d: got %h expected %h", nm, tag, act, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the next edge, then compare.
  task automatic apply(input vec_t v, input int tag);
    exp_t e;
    irq_raw_i        = v.raw;
    edge_mode_i      = v.mode;
    complete_valid_i = v.cv;
    complete_id_i    = v.cid;
    ovf_clr_i        = v.clr;
    e.req  = v.req;
    e.infl = v.infl;
    e.ovf  = v.ovf;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    e = sb.pop_front();
    check("irq_req", e.tag, irq_req_o, e.req);
    check("inflight", e.tag, inflight_o, e.infl);
    check("edge_ovf", e.tag, edge_ovf_o, e.ovf);
  endtask

  initial begin
    rst_ni           = 1'b0;
    irq_raw_i        = '0;
    edge_mode_i      = '0;
    complete_valid_i = 1'b0;
    complete_id_i    = '0;
    ovf_clr_i        = '0;
    #2;
    check("rst_req", 0, irq_req_o, '0);
    check("rst_inflight", 0, inflight_o, '0);
    check("rst_ovf", 0, edge_ovf_o, '0);
    @(posedge clk_i);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // Level source 3: pulse two edges after raw, hold-off, re-request after completion.
    tbl.push_back(mk('h008, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h008, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h008, 0, 0, 0, 0, 'h008, 'h008, 0));
    tbl.push_back(mk('h008, 0, 0, 0, 0, 0, 'h008, 0));
    tbl.push_back(mk('h008, 0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk('h008, 0, 0, 0, 0, 'h008, 'h008, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h008, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h008, 0));
    tbl.push_back(mk(0, 0, 1, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Edge source 5: three rises, three pulses each gated by a completion.
    tbl.push_back(mk('h020, 'h020, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h020, 'h020, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 'h020, 'h020, 0));
    tbl.push_back(mk('h020, 'h020, 0, 0, 0, 0, 'h020, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 0, 'h020, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 0, 'h020, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 0, 'h020, 0));
    tbl.push_back(mk(0, 'h020, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 'h020, 'h020, 0));
    tbl.push_back(mk(0, 'h020, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 'h020, 'h020, 0));
    tbl.push_back(mk(0, 'h020, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h020, 0, 0, 0, 0, 0, 0));

    // Edge source 7 with a 2-bit counter: five rises saturate, overflow wins over clear.
    for (int k = 0; k < 10; k++) begin
      tbl.push_back(mk((k % 2 == 0) ? 'h080 : 0, 'h080, 0, 0, 0,
                       (k == 3) ? 'h080 : 0, (k >= 3) ? 'h080 : 0, 0));
    end
    tbl.push_back(mk(0, 'h080, 0, 0, 'h080, 0, 'h080, 'h080));
    tbl.push_back(mk(0, 'h080, 0, 0, 0, 0, 'h080, 'h080));
    tbl.push_back(mk(0, 'h080, 0, 0, 'h080, 0, 'h080, 0));
    for (int k = 0; k < 3; k++) begin
      tbl.push_back(mk(0, 'h080, 1, 7, 0, 0, 0, 0));
      tbl.push_back(mk(0, 'h080, 0, 0, 0, 'h080, 'h080, 0));
    end
    tbl.push_back(mk(0, 'h080, 1, 7, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h080, 0, 0, 0, 0, 0, 0));

    // Level source 4: foreign, zero, out-of-range and invalid completions are ignored.
    tbl.push_back(mk('h010, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h010, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h010, 0, 0, 0, 0, 'h010, 'h010, 0));
    tbl.push_back(mk('h010, 0, 1, 9, 0, 0, 'h010, 0));
    tbl.push_back(mk('h010, 0, 1, 0, 0, 0, 'h010, 0));
    tbl.push_back(mk('h010, 0, 1, 13, 0, 0, 'h010, 0));
    tbl.push_back(mk('h010, 0, 0, 4, 0, 0, 'h010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h010, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 'h010, 0));
    tbl.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    // Edge source 6: a rise landing on the issue cycle leaves exactly one pending edge.
    tbl.push_back(mk('h040, 'h040, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h040, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h040, 'h040, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h040, 0, 0, 0, 'h040, 'h040, 0));
    tbl.push_back(mk(0, 'h040, 0, 0, 0, 0, 'h040, 0));
    tbl.push_back(mk('h040, 'h040, 0, 0, 0, 0, 'h040, 0));
    tbl.push_back(mk(0, 'h040, 1, 6, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h040, 0, 0, 0, 'h040, 'h040, 0));
    tbl.push_back(mk(0, 'h040, 1, 6, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h040, 0, 0, 0, 'h040, 'h040, 0));
    tbl.push_back(mk(0, 'h040, 1, 6, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h040, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h040, 0, 0, 0, 0, 0, 0));

    // Reserved source 0 in both modes never produces anything.
    for (int k = 0; k < 4; k++) tbl.push_back(mk('h001, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h001, 'h001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk('h001, 'h001, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 'h001, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));

    foreach (tbl[n]) apply(tbl[n], n + 1);

    // Source 2 BUSY, asynchronous reset mid-cycle, then a fresh request after release.
    apply(mk('h004, 0, 0, 0, 0, 0, 0, 0), 1001);
    apply(mk('h004, 0, 0, 0, 0, 0, 0, 0), 1002);
    apply(mk('h004, 0, 0, 0, 0, 'h004, 'h004, 0), 1003);
    apply(mk('h004, 0, 0, 0, 0, 0, 'h004, 0), 1004);
    #3;
    rst_ni = 1'b0;
    #1;
    check("arst_req", 1005, irq_req_o, '0);
    check("arst_inflight", 1005, inflight_o, '0);
    check("arst_ovf", 1005, edge_ovf_o, '0);
    #1;
    rst_ni = 1'b1;
    apply(mk('h004, 0, 0, 0, 0, 0, 0, 0), 1006);
    apply(mk('h004, 0, 0, 0, 0, 0, 0, 0), 1007);
    apply(mk('h004, 0, 0, 0, 0, 'h004, 'h004, 0), 1008);
    apply(mk(0, 0, 0, 0, 0, 0, 'h004, 0), 1009);
    apply(mk(0, 0, 0, 0, 0, 0, 'h004, 0), 1010);
    apply(mk(0, 0, 1, 2, 0, 0, 0, 0), 1011);
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0), 1012);

    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    tests++;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
